prog_loader: RTL and testbench

//  Boot-time program loader that fills the core's instruction ROM.
//  - Consumes a byte stream from a host link (UART RX or bench) via valid/ready.
//  - Assembles little-endian 32-bit instruction words and writes them to ROM word addresses 0..N-1.
//  - Holds the core in reset until a complete, checksum-valid image has been written.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_word_assembler.sv | 41 ++++
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } ld_state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; the first byte lands in [7:0].
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  // Only the three earlier bytes are stored; the fourth is taken straight from
  // the input so the word is available in the same cycle it completes.
  logic [23:0] lane;

  // Shift each accepted byte in from the top and count lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      lane     <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      lane     <= '0;
    end else if (byte_en) begin
      lane     <= {data_byte, lane[23:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Present the full word while the last lane's byte is being accepted.
  always_comb begin
    word       = {data_byte, lane};
    word_ready = byte_en && (byte_cnt == LAST_LANE);
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: LEN_LO, LEN_HI, 4*N data bytes, XOR checksum -> ROM writes, core release.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_din,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef logic [LEN_W:0] len_ext_t;
  localparam len_ext_t CAPACITY = len_ext_t'(2 ** ADDR_W);

  ld_state_t        state, state_next;
  logic             xfer, byte_en, asm_clr, word_ready, last_word;
  logic [31:0]      word;
  logic [7:0]       len_lo, csum;
  logic [LEN_W-1:0] len, new_len;
  logic [ADDR_W:0]  word_idx;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (asm_clr),
    .byte_en   (byte_en),
    .data_byte (in_data),
    .word      (word),
    .word_ready(word_ready)
  );

  // Handshake decode; kept apart from next-state logic to avoid a block-level loop through the assembler.
  always_comb begin
    in_ready = (state inside {LEN0, LEN1, DATA, CSUM}) && !restart;
    xfer     = in_valid && in_ready;
    byte_en  = xfer && (state == DATA);
  end

  // Next-state logic and assembler clear.
  always_comb begin
    state_next = state;
    asm_clr    = 1'b0;
    new_len    = {in_data, len_lo};
    last_word  = (len_ext_t'(word_idx) + len_ext_t'(1)) == len_ext_t'(len);
    if (restart) begin
      state_next = LEN0;
      asm_clr    = 1'b1;
    end else begin
      case (state)
        LEN0: if (xfer) state_next = LEN1;
        LEN1: begin
          asm_clr = 1'b1;
          if (xfer) begin
            if (new_len == '0 || len_ext_t'(new_len) > CAPACITY) state_next = ERROR;
            else                                                state_next = DATA;
          end
        end
        DATA: if (word_ready && last_word) state_next = CSUM;
        CSUM: if (xfer) state_next = (in_data == csum) ? DONE : ERROR;
        default: state_next = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LEN0;
    else        state <= state_next;
  end

  // Length/word counters, checksum, ROM write port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      csum       <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_din    <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      rom_we     <= 1'b0;
      done       <= (state_next == DONE);
      error      <= (state_next == ERROR);
      core_reset <= (state_next != DONE);
      if (restart) begin
        len      <= '0;
        word_idx <= '0;
        csum     <= '0;
      end else begin
        case (state)
          LEN0: if (xfer) len_lo <= in_data;
          LEN1: if (xfer) begin
            len      <= new_len;
            word_idx <= '0;
            csum     <= '0;
          end
          DATA: if (byte_en) begin
            csum <= csum ^ in_data;
            if (word_ready) begin
              rom_we   <= 1'b1;
              rom_addr <= word_idx[ADDR_W-1:0];
              rom_din  <= word;
              word_idx <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are built and judged by a byte-level model.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              restart = 1'b0;
  logic              in_ready, rom_we, core_reset, done, error;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_din;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  frame_q[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart   (restart),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_din   (rom_din),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned model_len();
    return int'({frame_q[1], frame_q[0]});
  endfunction

  function automatic logic model_len_ok();
    int unsigned n = model_len();
    return (n != 0) && (n <= (1 << ADDR_W));
  endfunction

  // Bytes the loader should take before it stops listening.
  function automatic int unsigned model_accepted();
    if (!model_len_ok()) return 2;
    return 2 + 4 * model_len() + 1;
  endfunction

  function automatic logic model_ok();
    logic [7:0] x = '0;
    int unsigned n = model_len();
    if (!model_len_ok()) return 1'b0;
    for (int unsigned i = 0; i < 4 * n; i++) x ^= frame_q[2 + i];
    return x == frame_q[2 + 4 * n];
  endfunction

  task automatic build_frame(input int unsigned n_words, input logic corrupt);
    logic [7:0]  b;
    logic [7:0]  x = '0;
    logic [15:0] n16 = 16'(n_words);
    frame_q = {};
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    for (int unsigned i = 0; i < 4 * n_words; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x ^= b;
    end
    frame_q.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Feed frame_q[0..stop_at-1], checking in_ready and every cycle's rom_we/addr/din.
  task automatic drive_frame(input int unsigned valid_pct, input int unsigned stop_at);
    int unsigned idx = 0;
    int unsigned budget = 30 * stop_at + 100;
    int unsigned n = model_len();
    logic v, rdy, go, exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_word;
    while (idx < stop_at) begin
      if (budget == 0) begin
        vectors++; miscompares++;
        $display("FAIL frame_timeout: accepted %0d bytes, required %0d", idx, stop_at);
        in_valid = 1'b0;
        return;
      end
      budget--;
      @(negedge clk);
      v = ($urandom_range(99) < valid_pct);
      in_valid = v;
      in_data  = frame_q[idx];
      #1;
      rdy = in_ready;
      vectors++;
      if (rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL in_ready_in_frame: byte %0d got %b expected 1", idx, rdy);
      end
      go = v && (rdy === 1'b1);
      exp_we = go && (idx >= 2) && ((idx - 2) < 4 * n) && (((idx - 2) % 4) == 3);
      @(posedge clk);
      #1;
      vectors++;
      if (rom_we !== exp_we) begin
        miscompares++;
        $display("FAIL rom_we: byte %0d got %b expected %b", idx, rom_we, exp_we);
      end
      if (exp_we) begin
        exp_addr = ADDR_W'((idx - 2) / 4);
        exp_word = {frame_q[idx], frame_q[idx-1], frame_q[idx-2], frame_q[idx-3]};
        vectors += 2;
        if (rom_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL rom_addr: got %0d expected %0d", rom_addr, exp_addr);
        end
        if (rom_din !== exp_word) begin
          miscompares++;
          $display("FAIL rom_din: got %h expected %h", rom_din, exp_word);
        end
      end
      if (go) idx++;
    end
    in_valid = 1'b0;
  endtask

  // Final status after the last accepted byte, then confirm further bytes are refused.
  task automatic check_outcome(input logic exp_done);
    vectors += 4;
    if (done !== exp_done) begin
      miscompares++; $display("FAIL done: got %b expected %b", done, exp_done);
    end
    if (error !== !exp_done) begin
      miscompares++; $display("FAIL error: got %b expected %b", error, !exp_done);
    end
    if (core_reset !== !exp_done) begin
      miscompares++; $display("FAIL core_reset: got %b expected %b", core_reset, !exp_done);
    end
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL in_ready_after_frame: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(posedge clk);
      #1;
      vectors += 2;
      if (rom_we !== 1'b0) begin
        miscompares++; $display("FAIL rom_we_idle: got %b expected 0", rom_we);
      end
      if (done !== exp_done) begin
        miscompares++; $display("FAIL done_hold: got %b expected %b", done, exp_done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    in_valid = 1'b0;
    restart  = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    #1;
    vectors += 4;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL restart_done: got %b expected 0", done);
    end
    if (error !== 1'b0) begin
      miscompares++; $display("FAIL restart_error: got %b expected 0", error);
    end
    if (core_reset !== 1'b1) begin
      miscompares++; $display("FAIL restart_core_reset: got %b expected 1", core_reset);
    end
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL restart_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors += 7;
    if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (core_reset !== 1'b1) begin miscompares++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
    if (rom_we !== 1'b0)     begin miscompares++; $display("FAIL rst_rom_we: got %b expected 0", rom_we); end
    if (done !== 1'b0)       begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    if (error !== 1'b0)      begin miscompares++; $display("FAIL rst_error: got %b expected 0", error); end
    if (rom_addr !== '0)     begin miscompares++; $display("FAIL rst_rom_addr: got %h expected 0", rom_addr); end
    if (rom_din !== '0)      begin miscompares++; $display("FAIL rst_rom_din: got %h expected 0", rom_din); end
  endtask

  task automatic test_single_word();
    frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    drive_frame(100, 7);
    check_outcome(1'b1);
    do_restart();
  endtask

  task automatic test_multi_word();
    build_frame(3, 1'b0);
    drive_frame(50, model_accepted());
    check_outcome(1'b1);
    do_restart();
  endtask

  task automatic test_bad_length();
    frame_q = {8'h00, 8'h00};
    drive_frame(100, 2);
    check_outcome(1'b0);
    do_restart();
    frame_q = {8'h01, 8'h01};
    drive_frame(100, 2);
    check_outcome(1'b0);
    do_restart();
  endtask

  task automatic test_csum_mismatch();
    frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    drive_frame(100, 7);
    check_outcome(1'b0);
    do_restart();
    frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    drive_frame(100, 7);
    check_outcome(1'b1);
    do_restart();
  endtask

  task automatic test_restart_4th_byte();
    build_frame(2, 1'b0);
    drive_frame(70, 5);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = frame_q[5];
    restart  = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rs4_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rom_we !== 1'b0) begin
      miscompares++; $display("FAIL rs4_rom_we: got %b expected 0", rom_we);
    end
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors += 2;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rs4_len0_ready: got %b expected 1", in_ready);
    end
    if (core_reset !== 1'b1) begin
      miscompares++; $display("FAIL rs4_core_reset: got %b expected 1", core_reset);
    end
    build_frame(1, 1'b0);
    drive_frame(100, model_accepted());
    check_outcome(1'b1);
    do_restart();
  endtask

  task automatic test_async_reset();
    build_frame(4, 1'b0);
    drive_frame(100, 8);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors += 6;
    if (rom_we !== 1'b0)     begin miscompares++; $display("FAIL ar_rom_we: got %b expected 0", rom_we); end
    if (rom_addr !== '0)     begin miscompares++; $display("FAIL ar_rom_addr: got %h expected 0", rom_addr); end
    if (rom_din !== '0)      begin miscompares++; $display("FAIL ar_rom_din: got %h expected 0", rom_din); end
    if (core_reset !== 1'b1) begin miscompares++; $display("FAIL ar_core_reset: got %b expected 1", core_reset); end
    if (done !== 1'b0 || error !== 1'b0) begin
      miscompares++; $display("FAIL ar_status: got done=%b error=%b expected 0 0", done, error);
    end
    if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    build_frame(2, 1'b0);
    drive_frame(100, model_accepted());
    check_outcome(1'b1);
    do_restart();
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      build_frame($urandom_range(1, 6), ($urandom_range(3) == 0));
      drive_frame($urandom_range(30, 100), model_accepted());
      check_outcome(model_ok());
      do_restart();
    end
  endtask

  task automatic test_max_len();
    build_frame(1 << ADDR_W, 1'b0);
    drive_frame(100, model_accepted());
    check_outcome(1'b1);
    do_restart();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_bad_length();
    test_csum_mismatch();
    test_restart_4th_byte();
    test_async_reset();
    test_random();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
